store_loader: RTL and testbench

- Boot-time program loader: the writer side of the main store, whose reader is the core's fetch/execute path.
- Accepts a byte stream over a valid/ready handshake and writes it into main store from address 0 upward.
- Holds the core in reset while loading, then releases it.
- Sits beside the core and muxes onto the main store read/write/address/data_i pins ahead of the core's MAR and bus.

---
 rtl/store_loader_pkg.sv | 20 ++
 rtl/store_loader.sv | 149 ++++++++++++++
 tb/tb_store_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_loader_pkg.sv
// Shared definitions for the boot-time program loader and the main store it feeds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package store_loader_pkg;

    // Defaults shared with the main store and the core's MAR.
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    // RD and CMP are only entered when read-back verification is built in.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DONE = 3'd2,
        RD   = 3'd3,
        CMP  = 3'd4
    } state_t;

endpackage

// File: rtl/store_loader.sv
// Boot loader: streams bytes into main store from address 0, holding the core in reset meanwhile.
// Latency: zero -- an accepted byte is written the same cycle (3 cycles per byte with LOADER_VERIFY_EN).
// Backpressure: in_ready only in LOAD; drops once DEPTH words are written or during read-back.
module store_loader
    import store_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BOOT_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ms_read,
    output logic              ms_write,
    output logic [ADDR_W-1:0] ms_address,
    output logic [DATA_W-1:0] ms_data_o,
    input  logic [DATA_W-1:0] ms_data_i,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              core_hold
`ifdef LOADER_VERIFY_EN
    ,
    output logic              err
`endif
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_inc;
    logic              hold_q;
    logic              hs;

    // Stream handshake drives the store pins directly so each byte lands with no added latency.
    assign in_ready   = (state == LOAD);
    assign hs         = in_valid & in_ready;
    assign cnt_inc    = cnt + (ADDR_W+1)'(1);
    assign ms_write   = hs;
    assign ms_address = ptr;
    assign ms_data_o  = hs ? in_data : '0;
    assign busy       = (state == LOAD) || (state == RD) || (state == CMP);
    assign done       = (state == DONE);
    assign count      = cnt;
    assign core_hold  = hold_q;

`ifdef LOADER_VERIFY_EN
    logic [DATA_W-1:0] byte_q;
    logic              last_q;
    logic              err_q;

    assign ms_read = (state == RD);
    assign err     = err_q;

    // Load FSM with read-back: every written word is read at the same address and compared.
    // The pointer only advances after a clean compare so RD reuses the write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            hold_q <= (BOOT_HOLD != 0);
            byte_q <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD;
                    ptr    <= '0;
                    cnt    <= '0;
                    hold_q <= 1'b1;
                    err_q  <= 1'b0;
                end
                LOAD: if (hs) begin
                    cnt    <= cnt_inc;
                    byte_q <= in_data;
                    last_q <= in_last;
                    state  <= RD;
                end
                RD: state <= CMP;
                CMP: begin
                    if (ms_data_i != byte_q) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end else if (last_q || (cnt == DEPTH_C)) begin
                        state <= DONE;
                    end else begin
                        ptr   <= ptr + ADDR_W'(1);
                        state <= LOAD;
                    end
                end
                DONE: begin
                    // A failed image keeps the core parked in reset.
                    hold_q <= err_q;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Read data is not consumed when read-back verification is absent.
    logic unused_rd;
    assign unused_rd = ^ms_data_i;
    assign ms_read   = 1'b0;

    // Load FSM: one byte per cycle; the pointer stops on the final word instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            hold_q <= (BOOT_HOLD != 0);
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD;
                    ptr    <= '0;
                    cnt    <= '0;
                    hold_q <= 1'b1;
                end
                LOAD: if (hs) begin
                    cnt <= cnt_inc;
                    if (in_last || (cnt_inc == DEPTH_C)) begin
                        state <= DONE;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                DONE: begin
                    hold_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_store_loader.sv
// Testbench for store_loader: bench-side main store plus a reference image model.
// Latency: n/a.
// Backpressure: stream source waits on in_ready.
module tb_store_loader;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DP = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          ms_read;
    logic          ms_write;
    logic [AW-1:0] ms_address;
    logic [DW-1:0] ms_data_o;
    logic [DW-1:0] ms_data_i;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          core_hold;
`ifdef LOADER_VERIFY_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    store_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP), .BOOT_HOLD(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ms_read(ms_read), .ms_write(ms_write), .ms_address(ms_address),
        .ms_data_o(ms_data_o), .ms_data_i(ms_data_i),
        .busy(busy), .done(done), .count(count), .core_hold(core_hold)
`ifdef LOADER_VERIFY_EN
        , .err(err)
`endif
    );

    // Bench-side main store and write monitor.
    logic [DW-1:0] mem     [DP];
    logic [DW-1:0] ref_mem [DP];
    int cyc = 0;
    int done_n = 0;
    int corrupt_addr = -1;
    int wr_addr[$];
    int wr_dat[$];
    int wr_cyc[$];

    initial begin
        for (int i = 0; i < DP; i++) begin
            mem[i]     = 8'h5A ^ 8'(i);
            ref_mem[i] = 8'h5A ^ 8'(i);
        end
    end

    always @(posedge clk) begin
        if (ms_write) begin
            mem[ms_address] <= ms_data_o;
            wr_addr.push_back(int'(ms_address));
            wr_dat.push_back(int'(ms_data_o));
            wr_cyc.push_back(cyc);
        end
        if (done) done_n++;
        ms_data_i <= (ms_read && int'(ms_address) == corrupt_addr) ? 8'hFF : mem[ms_address];
        cyc++;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        wr_addr.delete();
        wr_dat.delete();
        wr_cyc.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offers bytes (gap: 0 none, 1 every other cycle, 2 random) until done, or until
    // stop_after bytes are accepted. Returns the accepted count.
    task automatic run_load(input logic [7:0] b[$], input int last_idx, input int gap,
                            input int stop_after, output int acc);
        bit done_seen = 0;
        bit offer;
        int t = 0;
        acc = 0;
        while (!done_seen && acc < stop_after && t < 400) begin
            offer = (acc < b.size()) &&
                    !((gap == 1 && t % 2 == 1) || (gap == 2 && $urandom_range(0, 2) == 0));
            in_valid = offer;
            in_data  = offer ? b[acc] : 8'($urandom);
            in_last  = offer && (acc == last_idx);
            @(negedge clk);
            if (offer && acc >= DP) begin
                check("full_ready_low", in_ready, 0);
            end else if (offer && in_ready) begin
                check("wr_strobe", ms_write, 1);
                check("wr_addr_live", ms_address, acc);
                check("wr_data_live", ms_data_o, b[acc]);
            end else if (!offer && in_ready) begin
                check("gap_no_write", ms_write, 0);
                check("gap_addr_hold", ms_address, acc);
            end
            if (offer && in_ready) acc++;
            if (done) begin
                done_seen = 1;
                check("hold_during_done", core_hold, 1);
                check("busy_during_done", busy, 0);
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (stop_after > b.size()) check("load_terminated", done_seen, 1);
    endtask

    // Compares the finished load against the image the rules predict.
    task automatic finish_check(input logic [7:0] b[$], input int exp_n, input bit hold_exp,
                                input int done0);
        @(negedge clk);
        check("hold_after_done", core_hold, hold_exp);
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 0);
        check("count", count, exp_n);
        check("done_pulses", done_n - done0, 1);
        check("write_total", wr_addr.size(), exp_n);
        for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
            check("wr_addr_seq", wr_addr[i], i);
            check("wr_data_seq", wr_dat[i], b[i]);
        end
        for (int i = 0; i < exp_n; i++) ref_mem[i] = b[i];
        for (int i = 0; i < DP; i++) check("store_image", mem[i], ref_mem[i]);
    endtask

    initial begin
        logic [7:0] b[$];
        int acc, d0, n, li, en;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_core_hold", core_hold, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_count", count, 0);
        check("rst_ms_write", ms_write, 0);
        check("rst_ms_read", ms_read, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ms_address", ms_address, 0);
        check("rst_ms_data_o", ms_data_o, 0);

        // Three back-to-back bytes ending on in_last.
        b = {8'hA1, 8'h22, 8'h05};
        d0 = done_n;
        do_start();
        run_load(b, 2, 0, 1000, acc);
        finish_check(b, 3, 0, d0);
`ifndef LOADER_VERIFY_EN
        if (wr_cyc.size() == 3) begin
            check("b2b_cycle1", wr_cyc[1] - wr_cyc[0], 1);
            check("b2b_cycle2", wr_cyc[2] - wr_cyc[0], 2);
        end
`endif

        // Forty bytes, no in_last: capped at DEPTH.
        b.delete();
        for (int i = 0; i < 40; i++) b.push_back(8'($urandom));
        d0 = done_n;
        do_start();
        run_load(b, -1, 0, 1000, acc);
        check("full_accepted", acc, DP);
        finish_check(b, DP, 0, d0);

        // Gapped valid.
        b.delete();
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        d0 = done_n;
        do_start();
        run_load(b, 5, 1, 1000, acc);
        finish_check(b, 6, 0, d0);

        // Reset after 2 of 5 bytes.
        b.delete();
        for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
        do_start();
        run_load(b, 4, 0, 2, acc);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_hold", core_hold, 1);
        check("midrst_ready", in_ready, 0);
        check("midrst_count", count, 0);
        for (int i = 0; i < 2; i++) ref_mem[i] = b[i];
        for (int i = 0; i < DP; i++) check("midrst_store", mem[i], ref_mem[i]);
        b.delete();
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        d0 = done_n;
        do_start();
        run_load(b, 3, 0, 1000, acc);
        finish_check(b, 4, 0, d0);

        // Randomized loads.
        for (int k = 0; k < 6; k++) begin
            b.delete();
            if ($urandom_range(0, 3) == 0) begin
                n  = $urandom_range(DP, 40);
                li = -1;
                en = DP;
            end else begin
                n  = $urandom_range(1, 40);
                li = $urandom_range(0, n - 1);
                en = (li + 1 < DP) ? li + 1 : DP;
            end
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            d0 = done_n;
            do_start();
            run_load(b, li, 2, 1000, acc);
            finish_check(b, en, 0, d0);
        end

`ifdef LOADER_VERIFY_EN
        // Read-back mismatch on the first byte ends the load and keeps the core held.
        b = {8'h10, 8'h20};
        corrupt_addr = 0;
        d0 = done_n;
        do_start();
        run_load(b, 1, 0, 1000, acc);
        finish_check(b, 1, 1, d0);
        check("verify_err_set", err, 1);
        corrupt_addr = -1;
        b = {8'h33, 8'h44};
        d0 = done_n;
        do_start();
        @(negedge clk);
        check("verify_err_cleared", err, 0);
        @(posedge clk); #1;
        run_load(b, 1, 0, 1000, acc);
        finish_check(b, 2, 0, d0);
        check("verify_err_clean", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
